uart_rx_cfg: RTL and testbench

Parametrised UART receiver that generalises the fixed 8N1 receiver. It supports a configurable data width, oversampling ratio and baud divisor, plus runtime-selectable parity and stop-bit count. It takes 3-sample majority voting at bit centre, rejects false starts, and reports parity and framing errors alongside each received word. It sits between the board RS-232 pin and the UART/IIC command logic.

---
 rtl/uart_rx_cfg.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 3-sample majority vote at bit centre, runtime parity/stop select,
// parity and framing error flags. Define UART_RX_BREAK_DET_EN to add the Break output.
module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16,
  parameter int DIV_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rs232_Rx,
  input  logic [DIV_W-1:0]     Baud_Div,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Stop_Bits,
  output logic [DATA_BITS-1:0] Data_Byte,
  output logic                 Rx_Done,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 Break,
`endif
  output logic                 Busy
);

  // state    | meaning
  // S_IDLE   | line idle, counters held at 0, waiting for a falling edge
  // S_START  | start bit; majority 1 at mid-bit is a false start
  // S_DATA   | DATA_BITS data bits shifted in LSB first
  // S_PARITY | parity bit (skipped for parity modes 00/11)
  // S_STOP   | one or two stop bits; frame completes at mid-stop of the last one
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int TW  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0]  TICK_S0   = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0]  TICK_S1   = TW'(OSR / 2);
  localparam logic [TW-1:0]  TICK_MAJ  = TW'(OSR / 2 + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OSR - 1);
  localparam logic [BCW-1:0] BITS_LAST = BCW'(DATA_BITS);

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic [DIV_W-1:0]     cfg_div_q, cfg_div_d;
  logic [1:0]           cfg_par_q, cfg_par_d;
  logic                 cfg_stop2_q, cfg_stop2_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 zero_q, zero_d;
  logic                 break_q, break_d;
  logic                 zero_now;
`endif

  logic fall;
  logic tick;
  logic maj;
  logic bit_mid;
  logic bit_end;
  logic parity_en;
  logic frm_err_now;

  assign fall        = hist_q & ~sync2_q;
  assign tick        = (div_cnt_q == cfg_div_q);
  assign maj         = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign bit_mid     = (state_q != S_IDLE) && tick && (tick_cnt_q == TICK_MAJ);
  assign bit_end     = (state_q != S_IDLE) && tick && (tick_cnt_q == TICK_LAST);
  assign parity_en   = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
  assign frm_err_now = frm_err_q | ~maj;
`ifdef UART_RX_BREAK_DET_EN
  // Break needs data, parity and the first stop bit all low; later stop bits do not matter.
  assign zero_now    = stop_cnt_q ? zero_q : (zero_q & ~maj);
`endif

  always_comb begin
    state_d     = state_q;
    cfg_div_d   = cfg_div_q;
    cfg_par_d   = cfg_par_q;
    cfg_stop2_d = cfg_stop2_q;
    div_cnt_d   = '0;
    tick_cnt_d  = '0;
    bit_cnt_d   = bit_cnt_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    stop_cnt_d  = stop_cnt_q;
    data_d      = data_q;
    done_d      = 1'b0;
    perr_out_d  = perr_out_q;
    ferr_out_d  = ferr_out_q;
`ifdef UART_RX_BREAK_DET_EN
    zero_d      = zero_q;
    break_d     = 1'b0;
`endif

    if (state_q != S_IDLE) begin
      div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
      tick_cnt_d = tick_cnt_q;
      if (tick) begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        if (tick_cnt_q == TICK_S0) s0_d = sync2_q;
        if (tick_cnt_q == TICK_S1) s1_d = sync2_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d     = S_START;
          cfg_div_d   = Baud_Div;
          cfg_par_d   = Parity_Mode;
          cfg_stop2_d = Stop_Bits;
          bit_cnt_d   = '0;
          par_err_d   = 1'b0;
          frm_err_d   = 1'b0;
          stop_cnt_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          zero_d      = 1'b1;
`endif
        end
      end
      S_START: begin
        if (bit_mid && maj) state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_mid) begin
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          if (maj) zero_d = 1'b0;
`endif
        end
        if (bit_end && (bit_cnt_q == BITS_LAST)) state_d = parity_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_mid) begin
          // Odd mode wants an odd number of ones over data+parity, even mode an even number.
          par_err_d = (cfg_par_q == 2'b01) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
`ifdef UART_RX_BREAK_DET_EN
          if (maj) zero_d = 1'b0;
`endif
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_mid) begin
          frm_err_d = frm_err_now;
          if (cfg_stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            if (maj) zero_d = 1'b0;
`endif
          end else begin
            // Leave at mid-stop so a start edge right after the stop bit is not missed.
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            if (zero_now) begin
              break_d    = 1'b1;
              perr_out_d = 1'b0;
              ferr_out_d = 1'b0;
            end else begin
              data_d     = shift_q;
              perr_out_d = par_err_q;
              ferr_out_d = frm_err_now;
            end
`else
            data_d     = shift_q;
            perr_out_d = par_err_q;
            ferr_out_d = frm_err_now;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      state_q     <= S_IDLE;
      cfg_div_q   <= '0;
      cfg_par_q   <= 2'b00;
      cfg_stop2_q <= 1'b0;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      stop_cnt_q  <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q      <= 1'b0;
      break_q     <= 1'b0;
`endif
    end else begin
      sync1_q     <= Rs232_Rx;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      state_q     <= state_d;
      cfg_div_q   <= cfg_div_d;
      cfg_par_q   <= cfg_par_d;
      cfg_stop2_q <= cfg_stop2_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      stop_cnt_q  <= stop_cnt_d;
      data_q      <= data_d;
      done_q      <= done_d;
      perr_out_q  <= perr_out_d;
      ferr_out_q  <= ferr_out_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q      <= zero_d;
      break_q     <= break_d;
`endif
    end
  end

  assign Data_Byte  = data_q;
  assign Rx_Done    = done_q;
  assign Parity_Err = perr_out_q;
  assign Frame_Err  = ferr_out_q;
  assign Busy       = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign Break      = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus random frames checked against a line-level model.
module tb_uart_rx_cfg;
  localparam int OSR = 16;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Rs232_Rx;
  logic [15:0] Baud_Div;
  logic [1:0]  Parity_Mode;
  logic        Stop_Bits;
  logic [7:0]  Data_Byte;
  logic        Rx_Done;
  logic        Parity_Err;
  logic        Frame_Err;
  logic        Busy;
`ifdef UART_RX_BREAK_DET_EN
  logic        Break;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   busy_cycles = 0;
  int   double_done = 0;
  logic prev_done = 1'b0;
  logic [7:0] last_data = 8'h00;

  logic [7:0] obs_data[$];
  logic       obs_pe[$];
  logic       obs_fe[$];
  logic       obs_busy[$];
  int         obs_cyc[$];
`ifdef UART_RX_BREAK_DET_EN
  logic       obs_brk[$];
`endif

  uart_rx_cfg #(.DATA_BITS(8), .OSR(OSR), .DIV_W(16)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Rs232_Rx(Rs232_Rx),
    .Baud_Div(Baud_Div),
    .Parity_Mode(Parity_Mode),
    .Stop_Bits(Stop_Bits),
    .Data_Byte(Data_Byte),
    .Rx_Done(Rx_Done),
    .Parity_Err(Parity_Err),
    .Frame_Err(Frame_Err),
`ifdef UART_RX_BREAK_DET_EN
    .Break(Break),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Rx_Done) begin
      obs_data.push_back(Data_Byte);
      obs_pe.push_back(Parity_Err);
      obs_fe.push_back(Frame_Err);
      obs_busy.push_back(Busy);
      obs_cyc.push_back(cyc);
`ifdef UART_RX_BREAK_DET_EN
      obs_brk.push_back(Break);
`endif
      if (prev_done) double_done++;
    end
    prev_done = Rx_Done;
    if (Busy) busy_cycles++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    Rs232_Rx = lvl;
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_obs();
    obs_data = {};
    obs_pe   = {};
    obs_fe   = {};
    obs_busy = {};
    obs_cyc  = {};
`ifdef UART_RX_BREAK_DET_EN
    obs_brk  = {};
`endif
  endtask

  // Builds the frame as a list of line levels, drives it, and derives the expected result
  // from that list: data bits, ones count against parity mode, stop levels.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] pm, input logic s2,
                            input int bd, input logic flip_par, input int stop_low,
                            input int glitch_bit);
    logic       q[$];
    int         bitper, start_cyc, ones, nstop, lat, exp_lat, pen_i;
    logic       pbit, pen, perr_e, ferr_e;
    logic [7:0] data_e, d;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_e;
`endif
    Baud_Div    = 16'(bd);
    Parity_Mode = pm;
    Stop_Bits   = s2;
    @(negedge Clk);
    bitper = (bd + 1) * OSR;
    pen    = (pm == 2'b01) || (pm == 2'b10);
    pen_i  = pen ? 1 : 0;
    pbit   = (pm == 2'b01) ? ~(^data) : (^data);
    if (flip_par) pbit = ~pbit;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(data[i]);
    if (pen) q.push_back(pbit);
    nstop = s2 ? 2 : 1;
    for (int i = 1; i <= nstop; i++) q.push_back((stop_low == i) ? 1'b0 : 1'b1);

    for (int i = 0; i < 8; i++) data_e[i] = q[1 + i];
    ones = 0;
    for (int i = 1; i <= 8 + pen_i; i++) ones += (q[i] ? 1 : 0);
    perr_e = (pm == 2'b01) ? (ones % 2 == 0) : (pm == 2'b10) ? (ones % 2 == 1) : 1'b0;
    ferr_e = 1'b0;
    for (int i = 9 + pen_i; i < q.size(); i++) if (!q[i]) ferr_e = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    brk_e = (ones == 0) && !q[9 + pen_i];
    if (brk_e) begin
      data_e = last_data;
      perr_e = 1'b0;
      ferr_e = 1'b0;
    end
`endif

    start_cyc = cyc;
    for (int b = 0; b < q.size(); b++) begin
      if (b == glitch_bit) begin
        hold(q[b], bitper / 2);
        hold(~q[b], 1);
        hold(q[b], bitper - bitper / 2 - 1);
      end else begin
        hold(q[b], bitper);
      end
      if (b == 0) begin
        Baud_Div    = 16'($urandom_range(0, 3));
        Parity_Mode = 2'($urandom_range(0, 3));
        Stop_Bits   = 1'($urandom_range(0, 1));
      end
    end
    hold(1'b1, 4 + $urandom_range(0, 20));

    check("done_count", obs_data.size(), 1);
    check("busy_idle_after", Busy, 0);
    if (obs_data.size() > 0) begin
      d = obs_data.pop_front();
      check("data", d, data_e);
      check("parity_err", obs_pe.pop_front(), perr_e);
      check("frame_err", obs_fe.pop_front(), ferr_e);
      check("busy_at_done", obs_busy.pop_front(), 0);
      lat     = obs_cyc.pop_front() - start_cyc;
      exp_lat = 3 + bitper * q.size() - bitper / 2;
      check("done_latency", (lat >= exp_lat - bitper / 2) && (lat <= exp_lat + bitper / 2), 1);
`ifdef UART_RX_BREAK_DET_EN
      check("break", obs_brk.pop_front(), brk_e);
`endif
    end
    last_data = data_e;
    clear_obs();
  endtask

  initial begin
    logic [7:0] rd;
    int         sl, gb;
    Rst         = 1'b1;
    Rs232_Rx    = 1'b1;
    Baud_Div    = 16'd0;
    Parity_Mode = 2'b00;
    Stop_Bits   = 1'b0;
    repeat (4) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_data", Data_Byte, 0);
    check("rst_done", Rx_Done, 0);
    check("rst_perr", Parity_Err, 0);
    check("rst_ferr", Frame_Err, 0);
    check("rst_busy", Busy, 0);

    send_frame(8'hA5, 2'b00, 1'b0, 0, 1'b0, 0, -1);
    send_frame(8'h37, 2'b10, 1'b0, 0, 1'b0, 0, -1);
    send_frame(8'h37, 2'b10, 1'b0, 0, 1'b1, 0, -1);

    Baud_Div = 16'd0;
    @(negedge Clk);
    busy_cycles = 0;
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_no_done", obs_data.size(), 0);
    check("glitch_busy_seen", busy_cycles > 0, 1);
    check("glitch_busy_short", busy_cycles <= OSR / 2 + 2, 1);
    check("glitch_busy_end", Busy, 0);
    clear_obs();

    send_frame(8'h3C, 2'b00, 1'b1, 0, 1'b0, 2, -1);
    send_frame(8'h81, 2'b00, 1'b1, 0, 1'b0, 0, -1);
    send_frame(8'h5A, 2'b00, 1'b0, 0, 1'b0, 0, 4);

    Baud_Div    = 16'd0;
    Parity_Mode = 2'b00;
    Stop_Bits   = 1'b0;
    @(negedge Clk);
    hold(1'b0, 16);
    rd = 8'h5A;
    for (int i = 0; i < 4; i++) hold(rd[i], 16);
    hold(rd[4], 8);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("midrst_data", Data_Byte, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_ferr", Frame_Err, 0);
    hold(1'b1, 48);
    check("midrst_no_done", obs_data.size(), 0);
    last_data = 8'h00;
    clear_obs();
    send_frame(8'h5A, 2'b00, 1'b0, 0, 1'b0, 0, -1);

    Baud_Div    = 16'd0;
    Parity_Mode = 2'b00;
    Stop_Bits   = 1'b0;
    @(negedge Clk);
    hold(1'b0, 12 * OSR);
    check("brk_done_count", obs_data.size(), 1);
    check("brk_busy_low", Busy, 0);
    if (obs_data.size() > 0) begin
`ifdef UART_RX_BREAK_DET_EN
      check("brk_pulse", obs_brk.pop_front(), 1);
      check("brk_data_kept", obs_data.pop_front(), 8'h5A);
      check("brk_ferr", obs_fe.pop_front(), 0);
`else
      check("brk_data", obs_data.pop_front(), 8'h00);
      check("brk_ferr", obs_fe.pop_front(), 1);
      last_data = 8'h00;
`endif
    end
    clear_obs();
    hold(1'b1, 32);
    check("brk_no_retrigger", obs_data.size(), 0);
    clear_obs();

    for (int k = 0; k < 40; k++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 8'h00;
      sl = $urandom_range(0, 4);
      gb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
      send_frame(rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0), sl, gb);
    end

    check("no_double_done", double_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
